// File: rtl/unidade_mult_div.sv
// Iterative radix-2 multiply/divide unit holding the MIPS HI/LO registers.
// One operation takes 34 edges: capture (E0), PASSOS steps (E1..E32) and
// result write-back with the Pronto pulse (E33).
module unidade_mult_div #(
  parameter int LARGURA = 32,
  parameter int PASSOS  = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               Inicia,
  input  logic [1:0]         Operacao,
  input  logic [LARGURA-1:0] DadoRS,
  input  logic [LARGURA-1:0] DadoRT,
  input  logic               EscHI,
  input  logic               EscLO,
  output logic               Ocupado,
  output logic               Pronto,
  output logic [LARGURA-1:0] HI,
  output logic [LARGURA-1:0] LO
);

  localparam int W  = LARGURA;
  localparam int CW = (PASSOS > 1) ? $clog2(PASSOS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIM} estado_t;

  estado_t          estado;
  logic [CW-1:0]    cont;
  logic [1:0]       op;        // op[1]: divide, op[0]: signed
  logic [W-1:0]     mag_a;     // |DadoRS|: multiplicand (mult only)
  logic [W-1:0]     mag_b;     // |DadoRT|: divisor (div only)
  logic [2*W-1:0]   acc;       // mult: {partial sum, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]     raw_rs;    // unsigned copy of DadoRS for the divide-by-zero result
  logic             neg_q;     // negate product / quotient
  logic             neg_r;     // negate remainder

  // Operand conditioning at start: magnitudes and result signs
  logic [W-1:0]     abs_rs, abs_rt;
  logic             sgn;

  // One iteration step and the sign-corrected final results
  logic [W:0]       soma;
  logic [W:0]       r_sh;
  logic [W+1:0]     dif;
  logic [2*W-1:0]   passo;
  logic [2*W-1:0]   prod_c;
  logic [W-1:0]     quo_c, rem_c;

  // Magnitudes of the incoming operands (raw when unsigned)
  always_comb begin
    sgn    = Operacao[0];
    abs_rs = (sgn && DadoRS[W-1]) ? (~DadoRS + 1'b1) : DadoRS;
    abs_rt = (sgn && DadoRT[W-1]) ? (~DadoRT + 1'b1) : DadoRT;
  end

  // Shift-add multiply step / restoring divide step, plus final sign fix-up
  always_comb begin
    soma  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
    r_sh  = acc[2*W-1:W-1];
    dif   = {1'b0, r_sh} - {2'b00, mag_b};
    passo = acc;
    if (!op[1])
      passo = {soma, acc[W-1:1]};
    else if (dif[W+1])
      passo = {r_sh[W-1:0], acc[W-2:0], 1'b0};   // trial went negative: restore
    else
      passo = {dif[W-1:0], acc[W-2:0], 1'b1};
    prod_c = neg_q ? (~acc + 1'b1) : acc;
    quo_c  = neg_q ? (~acc[W-1:0] + 1'b1) : acc[W-1:0];
    rem_c  = neg_r ? (~acc[2*W-1:W] + 1'b1) : acc[2*W-1:W];
  end

  // Control FSM, datapath registers and HI/LO
  always_ff @(posedge clock) begin
    if (reset) begin
      estado  <= IDLE;
      cont    <= '0;
      op      <= '0;
      mag_a   <= '0;
      mag_b   <= '0;
      acc     <= '0;
      raw_rs  <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      Ocupado <= 1'b0;
      Pronto  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Pronto <= 1'b0;
      case (estado)
        IDLE: begin
          if (Inicia) begin
            op      <= Operacao;
            mag_a   <= abs_rs;
            mag_b   <= abs_rt;
            raw_rs  <= DadoRS;
            neg_q   <= sgn && (DadoRS[W-1] ^ DadoRT[W-1]);
            neg_r   <= sgn && DadoRS[W-1];
            // multiply iterates over the multiplier bits, divide over the dividend bits
            acc     <= Operacao[1] ? {{W{1'b0}}, abs_rs} : {{W{1'b0}}, abs_rt};
            cont    <= '0;
            Ocupado <= 1'b1;
            estado  <= RUN;
          end else begin
            if (EscHI) HI <= DadoRS;
            if (EscLO) LO <= DadoRS;
          end
        end
        RUN: begin
          acc <= passo;
          if (cont == CW'(PASSOS - 1))
            estado <= FIM;
          else
            cont <= cont + 1'b1;
        end
        FIM: begin
          if (op[1] && (mag_b == '0)) begin
            HI <= raw_rs;
            LO <= '1;
          end else if (op[1]) begin
            HI <= rem_c;
            LO <= quo_c;
          end else begin
            HI <= prod_c[2*W-1:W];
            LO <= prod_c[W-1:0];
          end
          Pronto  <= 1'b1;
          Ocupado <= 1'b0;
          estado  <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_mult_div.sv
// Randomized and directed checks of unidade_mult_div against an arithmetic
// reference model (64-bit products, truncating division).
module tb_unidade_mult_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        Inicia;
  logic [1:0]  Operacao;
  logic [31:0] DadoRS, DadoRT;
  logic        EscHI, EscLO;
  logic        Ocupado, Pronto;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  unidade_mult_div #(.LARGURA(32), .PASSOS(32)) dut (
    .clock(clock), .reset(reset), .Inicia(Inicia), .Operacao(Operacao),
    .DadoRS(DadoRS), .DadoRT(DadoRT), .EscHI(EscHI), .EscLO(EscLO),
    .Ocupado(Ocupado), .Pronto(Pronto), .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: returns {HI, LO}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint p, q, r;
    logic [63:0] res;
    case (o)
      2'b00: res = {32'b0, a} * {32'b0, b};
      2'b01: begin
        p   = longint'($signed(a)) * longint'($signed(b));
        res = p;
      end
      2'b10: res = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q   = longint'($signed(a)) / longint'($signed(b));
          r   = longint'($signed(a)) % longint'($signed(b));
          res = {r[31:0], q[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Launch one operation, optionally with MTHI/MTLO on the start edge and
  // with Inicia/EscHI/EscLO noise mid-run; checks timing and result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit esc_at_start, input bit disturb);
    logic [63:0] prev, exp;
    int n;
    bit seen;
    exp = model(o, a, b);
    @(negedge clock);
    prev     = {HI, LO};
    Inicia   = 1'b1;
    Operacao = o;
    DadoRS   = a;
    DadoRT   = b;
    EscHI    = esc_at_start;
    EscLO    = esc_at_start;
    @(posedge clock);
    @(negedge clock);
    Inicia = 1'b0; EscHI = 1'b0; EscLO = 1'b0;
    DadoRS = $urandom; DadoRT = $urandom;
    chk("start_ocupado", {63'b0, Ocupado}, 64'd1);
    chk("start_hold", {HI, LO}, prev);
    n = 1;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      if (n == 5 && disturb) begin
        Inicia = 1'b1; EscHI = 1'b1; EscLO = 1'b1; DadoRS = $urandom;
        Operacao = ~o;
      end
      if (n == 6) begin
        Inicia = 1'b0; EscHI = 1'b0; EscLO = 1'b0;
      end
      @(posedge clock);
      @(negedge clock);
      if (n == 20) chk("run_hold", {HI, LO}, prev);
      if (n == 32) chk("e32_ocup_pronto", {62'b0, Ocupado, Pronto}, 64'd2);
      if (Pronto) seen = 1'b1;
      else n++;
    end
    chk("latency", 64'(n), 64'd33);
    chk($sformatf("result op%0d %h %h", o, a, b), {HI, LO}, exp);
    chk("done_ocupado", {63'b0, Ocupado}, 64'd0);
    @(negedge clock);
    chk("pronto_pulse", {63'b0, Pronto}, 64'd0);
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] v);
    @(negedge clock);
    EscHI = h; EscLO = l; DadoRS = v;
    @(negedge clock);
    EscHI = 1'b0; EscLO = 1'b0;
  endtask

  initial begin
    int pcount;
    reset = 1'b1; Inicia = 1'b0; Operacao = 2'b00;
    DadoRS = '0; DadoRT = '0; EscHI = 1'b0; EscLO = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset_state", {60'b0, Ocupado, Pronto, |HI, |LO}, 64'd0);
    reset = 1'b0;

    // MTHI / MTLO
    mt(1'b1, 1'b0, 32'h1234);
    chk("mthi", {32'b0, HI}, 64'h1234);
    mt(1'b0, 1'b1, 32'h5678);
    chk("mtlo", {HI, LO}, {32'h1234, 32'h5678});
    mt(1'b1, 1'b1, 32'hCAFE);
    chk("mthi_mtlo", {HI, LO}, {32'hCAFE, 32'hCAFE});

    // Directed cases
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b1);
    run_op(2'b10, 32'd100, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op(2'b11, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b1);   // start wins over MTHI/MTLO

    // Reset mid-operation (counter at 10)
    @(negedge clock);
    Inicia = 1'b1; Operacao = 2'b00; DadoRS = 32'd3; DadoRT = 32'd4;
    @(posedge clock);
    @(negedge clock);
    Inicia = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_state", {Ocupado, Pronto, 30'b0, HI | LO}, 64'd0);
    pcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (Pronto || Ocupado) pcount++;
    end
    chk("abort_no_pronto", 64'(pcount), 64'd0);

    // Randomized operations
    for (int i = 0; i < 40; i++)
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
